tube_scan_ctrl: RTL and testbench

TUBE_SCAN_CTRL -- requirements
Module: tube_scan_ctrl

---
 rtl/tube_pkg.sv | 20 ++
 rtl/tube_hex2seg.sv | 14 +
 rtl/tube_scan_ctrl.sv | 162 ++++++++++++++++
 tb/tb_tube_scan_ctrl.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/tube_pkg.sv
// rtl/tube_pkg.sv - shared state encoding, segment table and default timing for the tube scanner
package tube_pkg;

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_SHOW = 2'd1,
        ST_GAP  = 2'd2
    } tube_state_t;

    localparam int DEF_NUM_DIGITS  = 8;
    localparam int DEF_SCAN_CNTMAX = 24999;
    localparam int DEF_GAP_CNTMAX  = 499;

    // Active-high {g,f,e,d,c,b,a}, indexed by hex value (element 15 listed first).
    localparam logic [15:0][6:0] HEX_SEG = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

endpackage

// File: rtl/tube_hex2seg.sv
// rtl/tube_hex2seg.sv - combinational hex nibble to active-low segment pattern with dp and blanking
module tube_hex2seg
    import tube_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       dp,
    input  logic       blank,
    output logic [7:0] seg_n
);

    // A blanked digit is fully dark, decimal point included.
    assign seg_n = blank ? 8'hFF : {~dp, ~HEX_SEG[nibble]};

endmodule

// File: rtl/tube_scan_ctrl.sv
// rtl/tube_scan_ctrl.sv - multiplexed 7-segment scanner with anti-ghost gaps and tear-free updates
module tube_scan_ctrl
    import tube_pkg::*;
#(
    parameter int NUM_DIGITS  = DEF_NUM_DIGITS,
    parameter int SCAN_CNTMAX = DEF_SCAN_CNTMAX,
    parameter int GAP_CNTMAX  = DEF_GAP_CNTMAX
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        wr_valid,
    input  logic [31:0] wr_data,
    input  logic [7:0]  wr_dp,
    input  logic [7:0]  wr_blank,
    output logic        wr_ready,
    output logic [7:0]  seg_n,
    output logic [7:0]  sel_n,
    output logic        frame_done
);

    localparam int CNT_MAX = (SCAN_CNTMAX > GAP_CNTMAX) ? SCAN_CNTMAX : GAP_CNTMAX;
    localparam int CNT_W   = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;
    localparam logic [CNT_W-1:0] SCAN_LIM = CNT_W'(SCAN_CNTMAX);
    localparam logic [CNT_W-1:0] GAP_LIM  = CNT_W'(GAP_CNTMAX);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [2:0]       LAST_IDX = 3'(NUM_DIGITS - 1);

    tube_state_t      state, state_nxt;
    logic [2:0]       idx, idx_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             fd_nxt;

    logic             pend_full;
    logic [31:0]      pend_data;
    logic [7:0]       pend_dp;
    logic [7:0]       pend_blank;

    logic [31:0]      disp_data, disp_data_n;
    logic [7:0]       disp_dp, disp_dp_n;
    logic [7:0]       disp_blank, disp_blank_n;

    logic             accept;
    logic             commit;
    logic [7:0]       sel_dec;
    logic [7:0]       dec_seg_n;

    assign wr_ready = !pend_full;
    assign accept   = wr_valid && !pend_full;

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        cnt_nxt   = cnt;
        fd_nxt    = 1'b0;
        if (!en) begin
            state_nxt = ST_OFF;
            idx_nxt   = 3'd0;
            cnt_nxt   = '0;
        end else begin
            case (state)
                ST_OFF: begin
                    state_nxt = ST_SHOW;
                    idx_nxt   = 3'd0;
                    cnt_nxt   = '0;
                end
                ST_SHOW: begin
                    if (cnt >= SCAN_LIM) begin
                        state_nxt = ST_GAP;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + CNT_ONE;
                    end
                end
                ST_GAP: begin
                    if (cnt >= GAP_LIM) begin
                        state_nxt = ST_SHOW;
                        cnt_nxt   = '0;
                        if (idx >= LAST_IDX) begin
                            idx_nxt = 3'd0;
                            fd_nxt  = 1'b1;
                        end else begin
                            idx_nxt = idx + 3'd1;
                        end
                    end else begin
                        cnt_nxt = cnt + CNT_ONE;
                    end
                end
                default: begin
                    state_nxt = ST_OFF;
                    idx_nxt   = 3'd0;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    // Pending data only reaches the display between frames, so a frame never mixes old and new digits.
    assign commit       = pend_full && ((state == ST_OFF) || fd_nxt);
    assign disp_data_n  = commit ? pend_data  : disp_data;
    assign disp_dp_n    = commit ? pend_dp    : disp_dp;
    assign disp_blank_n = commit ? pend_blank : disp_blank;

    // Decode from next-state values so pins are loaded on the very edge the slot starts.
    tube_hex2seg u_hex2seg (
        .nibble (disp_data_n[{idx_nxt, 2'b00} +: 4]),
        .dp     (disp_dp_n[idx_nxt]),
        .blank  (disp_blank_n[idx_nxt]),
        .seg_n  (dec_seg_n)
    );

    always_comb begin
        sel_dec = 8'hFF;
        for (int i = 0; i < 8; i++) begin
            if ((i < NUM_DIGITS) && (idx_nxt == 3'(i))) begin
                sel_dec[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_OFF;
            idx        <= 3'd0;
            cnt        <= '0;
            sel_n      <= 8'hFF;
            seg_n      <= 8'hFF;
            frame_done <= 1'b0;
            pend_full  <= 1'b0;
            pend_data  <= '0;
            pend_dp    <= '0;
            pend_blank <= 8'hFF;
            disp_data  <= '0;
            disp_dp    <= '0;
            disp_blank <= 8'hFF;
        end else begin
            state      <= state_nxt;
            idx        <= idx_nxt;
            cnt        <= cnt_nxt;
            frame_done <= fd_nxt;
            if (state_nxt == ST_SHOW) begin
                sel_n <= sel_dec;
                seg_n <= dec_seg_n;
            end else begin
                sel_n <= 8'hFF;
                seg_n <= 8'hFF;
            end
            if (accept) begin
                pend_full  <= 1'b1;
                pend_data  <= wr_data;
                pend_dp    <= wr_dp;
                pend_blank <= wr_blank;
            end else if (commit) begin
                pend_full <= 1'b0;
            end
            disp_data  <= disp_data_n;
            disp_dp    <= disp_dp_n;
            disp_blank <= disp_blank_n;
        end
    end

endmodule

// File: tb/tb_tube_scan_ctrl.sv
// tb/tb_tube_scan_ctrl.sv - scoreboard bench for tube_scan_ctrl with a 4-digit short-timing build
module tb_tube_scan_ctrl;

    localparam int ND   = 4;
    localparam int SCAN = 3;
    localparam int GAP  = 1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        wr_valid;
    logic [31:0] wr_data;
    logic [7:0]  wr_dp;
    logic [7:0]  wr_blank;
    logic        wr_ready;
    logic [7:0]  seg_n;
    logic [7:0]  sel_n;
    logic        frame_done;

    tube_scan_ctrl #(
        .NUM_DIGITS  (ND),
        .SCAN_CNTMAX (SCAN),
        .GAP_CNTMAX  (GAP)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .wr_valid   (wr_valid),
        .wr_data    (wr_data),
        .wr_dp      (wr_dp),
        .wr_blank   (wr_blank),
        .wr_ready   (wr_ready),
        .seg_n      (seg_n),
        .sel_n      (sel_n),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] sel;
        logic [7:0] seg;
    } slot_t;

    slot_t       exp_q[$];
    int          n_chk  = 0;
    int          n_pass = 0;
    int          cyc    = 0;
    bit          mon_on = 1'b0;
    bit          skip_len = 1'b0;
    logic [7:0]  prev_sel = 8'hFF;
    int          slot_len = 0;

    logic [31:0] md_data;
    logic [7:0]  md_dp;
    logic [7:0]  md_bl;

    logic [7:0]  seg_tbl [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                  8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
    endtask

    function automatic logic [7:0] seg_exp(input logic [3:0] nib, input logic dp, input logic bl);
        logic [7:0] s;
        s = seg_tbl[nib];
        if (dp) s[7] = 1'b0;
        return bl ? 8'hFF : s;
    endfunction

    task automatic push_frame();
        slot_t e;
        for (int i = 0; i < ND; i++) begin
            e.sel = 8'hFF;
            e.sel[i] = 1'b0;
            e.seg = seg_exp(md_data[i*4 +: 4], md_dp[i], md_bl[i]);
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_sel(input logic [7:0] s, input string tag);
        bit found = 1'b0;
        for (int k = 0; k < 200 && !found; k++) begin
            @(posedge clk); #1;
            if (sel_n === s) found = 1'b1;
        end
        if (!found) chk(tag, 32'd0, 32'd1);
    endtask

    task automatic wait_fd(input string tag);
        bit found = 1'b0;
        for (int k = 0; k < 200 && !found; k++) begin
            @(posedge clk); #1;
            if (frame_done === 1'b1) found = 1'b1;
        end
        if (!found) chk(tag, 32'd0, 32'd1);
    endtask

    task automatic drive_write(input logic [31:0] d, input logic [7:0] dp, input logic [7:0] bl);
        chk("wr_ready_before_write", 32'(wr_ready), 32'd1);
        wr_valid = 1'b1;
        wr_data  = d;
        wr_dp    = dp;
        wr_blank = bl;
        @(posedge clk); #1;
        wr_valid = 1'b0;
        chk("wr_ready_after_accept", 32'(wr_ready), 32'd0);
    endtask

    // Slot monitor: each lit slot start pops one expectation; gaps must be dark.
    always @(negedge clk) begin
        slot_t e;
        if (mon_on) begin
            if (sel_n !== 8'hFF && prev_sel === 8'hFF) begin
                if (exp_q.size() == 0) begin
                    chk("slot_unexpected", 32'(sel_n), 32'hFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("slot_sel", 32'(sel_n), 32'(e.sel));
                    chk("slot_seg", 32'(seg_n), 32'(e.seg));
                end
                slot_len = 1;
            end else if (sel_n !== 8'hFF) begin
                slot_len++;
            end else begin
                chk("gap_seg_dark", 32'(seg_n), 32'hFF);
                if (prev_sel !== 8'hFF && !skip_len) chk("slot_len", 32'(slot_len), 32'(SCAN + 1));
            end
        end
        prev_sel = sel_n;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        rst_n = 1'b0; en = 1'b0; wr_valid = 1'b0;
        wr_data = '0; wr_dp = '0; wr_blank = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_sel_n", 32'(sel_n), 32'hFF);
        chk("rst_seg_n", 32'(seg_n), 32'hFF);
        chk("rst_wr_ready", 32'(wr_ready), 32'd1);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        rst_n = 1'b1;
        mon_on = 1'b1;

        // Update while off commits on the next edge.
        drive_write(32'h0000_1234, 8'h00, 8'h00);
        @(posedge clk); #1;
        chk("off_commit_wr_ready", 32'(wr_ready), 32'd1);
        md_data = 32'h0000_1234; md_dp = 8'h00; md_bl = 8'h00;

        en = 1'b1;
        push_frame();
        @(posedge clk); #1;
        chk("first_slot_sel", 32'(sel_n), 32'hFE);
        wait_fd("fd_frame2_timeout");
        push_frame();
        t0 = cyc;
        @(posedge clk); #1;
        chk("frame_done_one_cycle", 32'(frame_done), 32'd0);
        wait_fd("fd_frame3_timeout");
        chk("frame_period", 32'(cyc - t0), 32'(ND * (SCAN + GAP + 2)));
        push_frame();

        // Mid-frame update, then a second request held while pending is full.
        wait_sel(8'hFD, "wait_digit1_timeout");
        drive_write(32'h0000_ABCD, 8'h00, 8'h00);
        wr_valid = 1'b1; wr_data = 32'h0000_5678; wr_dp = 8'h01; wr_blank = 8'h04;
        repeat (3) @(posedge clk);
        #1;
        chk("pending_blocks_ready", 32'(wr_ready), 32'd0);
        wait_fd("fd_frame4_timeout");
        chk("ready_after_wrap", 32'(wr_ready), 32'd1);
        md_data = 32'h0000_ABCD; md_dp = 8'h00; md_bl = 8'h00;
        push_frame();
        @(posedge clk); #1;
        wr_valid = 1'b0;
        chk("second_write_accepted", 32'(wr_ready), 32'd0);
        wait_fd("fd_frame5_timeout");
        md_data = 32'h0000_5678; md_dp = 8'h01; md_bl = 8'h04;
        push_frame();

        // Drop enable during digit 2, then restart.
        wait_sel(8'hFB, "wait_digit2_timeout");
        skip_len = 1'b1;
        en = 1'b0;
        @(posedge clk); #1;
        chk("en_off_sel", 32'(sel_n), 32'hFF);
        chk("en_off_seg", 32'(seg_n), 32'hFF);
        chk("abort_leftover_slots", 32'(exp_q.size()), 32'd1);
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1;
        chk("off_stays_dark", 32'(sel_n), 32'hFF);
        en = 1'b1;
        skip_len = 1'b0;
        push_frame();
        @(posedge clk); #1;
        chk("restart_digit0", 32'(sel_n), 32'hFE);

        // Reset in a gap with pending data.
        wait_sel(8'hFD, "wait_digit1b_timeout");
        drive_write(32'h0000_9999, 8'h0F, 8'h00);
        wait_sel(8'hFF, "wait_gap_timeout");
        #1;
        mon_on = 1'b0;
        exp_q.delete();
        rst_n = 1'b0;
        en = 1'b0;
        #1;
        chk("async_rst_sel", 32'(sel_n), 32'hFF);
        chk("async_rst_seg", 32'(seg_n), 32'hFF);
        chk("async_rst_wr_ready", 32'(wr_ready), 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        mon_on = 1'b1;
        md_data = 32'h0; md_dp = 8'h00; md_bl = 8'hFF;
        en = 1'b1;
        push_frame();
        wait_fd("fd_after_reset_timeout");
        mon_on = 1'b0;
        chk("blank_frame_consumed", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
